// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit with HI/LO registers for the pipelined MIPS core.
// Radix-2 shift-add multiply or restoring divide, one bit per cycle over WIDTH cycles.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic             read_hilo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t             state;
    logic [CW-1:0]      count;
    logic               is_div;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   dividend_raw;
    logic [2*WIDTH-1:0] acc;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   res_hi;
    logic [WIDTH-1:0]   res_lo;

    assign a_neg = ~op[0] & srca[WIDTH-1];
    assign b_neg = ~op[0] & srcb[WIDTH-1];
    assign a_abs = a_neg ? -srca : srca;
    assign b_abs = b_neg ? -srcb : srcb;

    assign stall = busy & (start | read_hilo | hi_we | lo_we);

    // acc holds {partial product, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff    = shifted - {1'b0, mcand};
        if (!is_div)
            acc_next = {add_sum, acc[WIDTH-1:1]};
        else if (!diff[WIDTH])
            acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        else
            acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    // Remainder follows the dividend's sign; a zero divisor bypasses the datapath result
    always_comb begin
        res_hi = acc[2*WIDTH-1:WIDTH];
        res_lo = acc[WIDTH-1:0];
        if (!is_div) begin
            if (sign_a ^ sign_b)
                {res_hi, res_lo} = -acc;
        end else if (mcand == '0) begin
            res_hi = dividend_raw;
            res_lo = '1;
        end else begin
            if (sign_a ^ sign_b)
                res_lo = -acc[WIDTH-1:0];
            if (sign_a)
                res_hi = -acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            is_div       <= 1'b0;
            sign_a       <= 1'b0;
            sign_b       <= 1'b0;
            mcand        <= '0;
            dividend_raw <= '0;
            acc          <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            hi           <= '0;
            lo           <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we)
                        hi <= wdata;
                    if (lo_we)
                        lo <= wdata;
                    if (start) begin
                        is_div       <= op[1];
                        sign_a       <= a_neg;
                        sign_b       <= b_neg;
                        dividend_raw <= srca;
                        mcand        <= op[1] ? b_abs : a_abs;
                        acc          <= {{WIDTH{1'b0}}, (op[1] ? a_abs : b_abs)};
                        count        <= '0;
                        busy         <= 1'b1;
                        state        <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        done  <= 1'b1;
                        state <= FIX;
                    end
                end
                FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit with its sequencing FSM and the HI/LO architectural registers for the pipelined MIPS core.
- Sits beside the execute stage. Accepts MULT/MULTU/DIV/DIVU, MTHI and MTLO from E.
- Runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles.
- Raises a stall request to the hazard logic while a later HI/LO access would collide with an operation in flight.

Parameters:
WIDTH, 32, operand width; iteration count per operation; HI/LO width.

Ports:
clk  input  1  core clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  E-stage mult/div instruction valid
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
srca  input  WIDTH  rs operand (multiplicand / dividend)
srcb  input  WIDTH  rt operand (multiplier / divisor)
hi_we  input  1  MTHI in E
lo_we  input  1  MTLO in E
wdata  input  WIDTH  MTHI/MTLO data
read_hilo  input  1  MFHI/MFLO in E
busy  output  1  operation in flight
stall  output  1  stall request to hazard unit (freeze F/D/E, bubble M)
done  output  1  one-cycle pulse in final (FIX) cycle
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async): state=IDLE, count=0, hi=lo=0, busy=stall=done=0, internal accumulators 0. Reset mid-operation aborts the operation. No partial result reaches hi/lo.
- FSM states: IDLE, RUN, FIX.
  - IDLE: on start at an edge (edge 0), latch op, sign flags, |srca| and |srcb|. For unsigned ops, signs are 0 and values are used raw. count:=0. Go to RUN.
  - RUN: one iteration per edge; count increments. After the WIDTH-th RUN edge, go to FIX.
    - Multiply: 2*WIDTH-bit product register, shift-add, LSB first.
    - Divide: restoring; remainder/quotient register pair, one quotient bit per edge, MSB first.
  - FIX: done=1. At the edge: apply sign correction, write hi/lo, go to IDLE.
- Latency: hi/lo hold the new result after edge WIDTH+1 (edge 33 for WIDTH=32). busy=1 from the cycle after edge 0 through the FIX cycle inclusive.
- Result rules:
  - MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product. Product is negated if sign_a^sign_b (MULT only).
  - DIV/DIVU: lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
  - Divide by zero (any sign): lo=all ones, hi=srca as latched at start.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- stall = busy & (start | read_hilo | hi_we | lo_we).
  - A start while busy is not accepted. The instruction is held by the stall and accepted at the first edge in IDLE.
  - MTHI/MTLO while busy does not write until IDLE.
  - In the FIX cycle stall is still asserted. The held MFHI/MFLO sees the new hi/lo in the following cycle.
- In IDLE: hi_we writes hi:=wdata and lo_we writes lo:=wdata at the edge. No stall.
  - If start coincides with hi_we/lo_we, the write happens and start is accepted. The later result overwrites HI/LO.
- hi/lo are stable (old values) throughout RUN. An MFHI/MFLO not asserted during busy is never stalled.
- Operands srca/srcb may change after edge 0 without effect.

Test Plan:
- MULT 0xFFFFFFFE x 0x00000003 -> after 33 edges hi=0xFFFFFFFF, lo=0xFFFFFFFA; done high exactly one cycle; busy low the next cycle.
- MULTU 0xFFFFFFFE x 0x00000003 -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV 0xFFFFFFF9 / 0x00000002 (-7/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 0x00000064 / 0x00000007 -> lo=0x0000000E, hi=0x00000002.
- DIVU 0x12345678 / 0 and DIV 0x80000000 / 0xFFFFFFFF -> lo=0xFFFFFFFF, hi=0x12345678; then lo=0x80000000, hi=0.
- MULT accepted, then read_hilo held high from the next cycle -> stall=1 through the FIX cycle, 0 afterwards. A second start during busy is not accepted until IDLE. MTLO 0x5 in IDLE -> lo=0x5 next edge with stall=0.
- reset asserted asynchronously mid-RUN (count=10, hi=lo=0xAAAAAAAA beforehand) -> immediately state IDLE, busy=0, hi=lo=0, no done pulse. A fresh MULTU 7x6 then gives lo=42, hi=0.
